// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving two requesters access to a two-bank async SRAM.
// Latency: ack at t+2+STROBE_CYC on a decode hit, t+1 on a decode miss.
// Backpressure: the losing requester is held off by withholding ack; the requester must hold req until ack.
module mem_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STROBE_CYC = 2
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [11:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          CE0_n,
    output logic          CE1_n,
    output logic          OE_n,
    output logic          WE_n
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ERR
    } state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    localparam logic [19:0] BANK0_PAGE = 20'h10000;
    localparam logic [19:0] BANK1_PAGE = 20'h14000;
    localparam logic [3:0]  LAST_CNT   = 4'(STROBE_CYC - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       pri;      // requester that wins when both ask
    logic       gnt;      // requester owning the current transaction
    logic       txn_we;

    logic       sel1;
    req_t       sel;
    logic [19:0] page;
    logic       hit0;
    logic       hit1;

    always_comb begin
        sel1 = req1 && (!req0 || pri);
        sel  = sel1 ? '{we: we1, addr: addr1, wdata: wdata1}
                    : '{we: we0, addr: addr0, wdata: wdata0};
        page = 20'(sel.addr >> 12);
        hit0 = (page == BANK0_PAGE);
        hit1 = (page == BANK1_PAGE);
    end

    // All strobes and acks are registered; the async reset releases the bus the instant nRESET falls.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            pri       <= 1'b0;
            gnt       <= 1'b0;
            txn_we    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            CE0_n     <= 1'b1;
            CE1_n     <= 1'b1;
            OE_n      <= 1'b1;
            WE_n      <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt       <= sel1;
                        txn_we    <= sel.we;
                        mem_addr  <= sel.addr[11:0];
                        mem_wdata <= sel.wdata;
                        busy      <= 1'b1;
                        if (hit0 || hit1) begin
                            state <= SETUP;
                            CE0_n <= !hit0;
                            CE1_n <= !hit1;
                        end else begin
                            state <= ERR;
                            ack0  <= !sel1;
                            ack1  <= sel1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    cnt   <= '0;
                    OE_n  <= txn_we;
                    WE_n  <= !txn_we;
                end
                STROBE: begin
                    if (cnt == LAST_CNT) begin
                        state <= HOLD;
                        cnt   <= '0;
                        OE_n  <= 1'b1;
                        WE_n  <= 1'b1;
                        ack0  <= !gnt;
                        ack1  <= gnt;
                        if (!txn_we) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                    CE0_n <= 1'b1;
                    CE1_n <= 1'b1;
                    busy  <= 1'b0;
                    pri   <= !gnt;
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    pri   <= !gnt;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    CE0_n <= 1'b1;
                    CE1_n <= 1'b1;
                    OE_n  <= 1'b1;
                    WE_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule
